// File: rtl/cache_mem_arbiter.sv
// Single main-memory port shared between I-cache refills and D-cache refills/write-backs.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; the default is fixed D>I priority.
module cache_mem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_rvalid,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_wready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFF_W  = $clog2(BYTES);
   localparam int BEAT_W = $clog2(BURST_LEN);
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * BYTES - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, I_XFER, D_XFER} state_t;

   state_t              state, next;
   logic [BEAT_W-1:0]   beat;
   logic [ADDR_W-1:0]   base;
   logic                we_lat;
   logic                xfer, last, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;

   // Flag remembers which port won the previous grant; reset favours I so D wins first.
   always_ff @(posedge clk) begin
      if (rst)
         last_d <= 1'b0;
      else if (state == IDLE && next != IDLE)
         last_d <= (next == D_XFER);
   end

   assign pick_d = !last_d;
`else
   assign pick_d = 1'b1;
`endif

   assign xfer = (state != IDLE);
   assign last = xfer && mem_ack && (beat == LAST_BEAT);

   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (d_req && i_req) next = pick_d ? D_XFER : I_XFER;
            else if (d_req)     next = D_XFER;
            else if (i_req)     next = I_XFER;
         end
         I_XFER, D_XFER: if (last) next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= 2'b00;
         busy   <= 1'b0;
         beat   <= '0;
         base   <= '0;
         we_lat <= 1'b0;
      end else begin
         state <= next;
         grant <= (next == I_XFER) ? 2'b01 : (next == D_XFER) ? 2'b10 : 2'b00;
         busy  <= (next != IDLE);
         if (state == IDLE && next != IDLE) begin
            base   <= ((next == D_XFER) ? d_addr : i_addr) & ~LINE_MASK;
            we_lat <= (next == D_XFER) && d_we;
            beat   <= '0;
         end else if (xfer && mem_ack) begin
            beat <= beat + 1'b1;
         end
      end
   end

   assign mem_req   = xfer;
   assign mem_we    = (state == D_XFER) && we_lat;
   assign mem_addr  = xfer ? base + (ADDR_W'(beat) << OFF_W) : '0;
   assign mem_wdata = mem_we ? d_wdata : '0;

   assign i_rvalid  = (state == I_XFER) && mem_ack;
   assign i_rdata   = i_rvalid ? mem_rdata : '0;
   assign i_done    = (state == I_XFER) && last && !rst;

   assign d_rvalid  = (state == D_XFER) && !we_lat && mem_ack;
   assign d_rdata   = d_rvalid ? mem_rdata : '0;
   assign d_wready  = (state == D_XFER) && we_lat && mem_ack;
   assign d_done    = (state == D_XFER) && last && !rst;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: refills, write-back, priority, reset and request-drop cases.
module tb_cache_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_ack;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_rvalid, i_done, d_wready, d_rvalid, d_done, mem_req, mem_we, busy;
   logic [1:0]  grant;

   int unsigned vecs = 0;
   int unsigned errs = 0;

   always #5 clk = ~clk;

   // Memory returns a data word derived from the beat address.
   assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      vecs++;
      if ({grant, busy, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0 ||
          {i_rvalid, i_done, d_rvalid, d_done, d_wready} !== 5'b0) begin
         errs++;
         $display("FAIL reset: grant=%b busy=%b req=%b we=%b addr=%h, want all zero",
                  grant, busy, mem_req, mem_we, mem_addr);
      end
   endtask

   task automatic test_i_refill();
      i_req = 1; i_addr = 32'h104;
      tick();
      vecs++;
      if (grant !== 2'b01 || busy !== 1'b1) begin
         errs++; $display("FAIL i_grant: grant=%b busy=%b, want 01/1", grant, busy);
      end
      mem_ack = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         vecs++;
         if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 + 32'(4*k) ||
             i_rvalid !== 1'b1 || i_rdata !== ((32'h100 + 32'(4*k)) ^ 32'hDEAD_0000) ||
             i_done !== (k == 3) || d_rvalid !== 1'b0) begin
            errs++;
            $display("FAIL i_beat%0d: req=%b we=%b addr=%h rv=%b rd=%h done=%b, want addr=%h",
                     k, mem_req, mem_we, mem_addr, i_rvalid, i_rdata, i_done, 32'h100 + 32'(4*k));
         end
         tick();
      end
      mem_ack = 0; i_req = 0;
      #1;
      vecs++;
      if (busy !== 1'b0 || grant !== 2'b00 || mem_req !== 1'b0) begin
         errs++; $display("FAIL i_end: busy=%b grant=%b req=%b, want 0/00/0", busy, grant, mem_req);
      end
      tick();
   endtask

   task automatic test_priority();
      i_req = 1; i_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h1008;
      tick();
      vecs++;
      if (grant !== 2'b10) begin
         errs++; $display("FAIL prio_grant: grant=%b, want 10", grant);
      end
      mem_ack = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         vecs++;
         if (mem_addr !== 32'h1000 + 32'(4*k) || d_rvalid !== 1'b1 || i_rvalid !== 1'b0 ||
             d_rdata !== ((32'h1000 + 32'(4*k)) ^ 32'hDEAD_0000) || d_done !== (k == 3) ||
             i_done !== 1'b0) begin
            errs++;
            $display("FAIL prio_d_beat%0d: addr=%h drv=%b irv=%b rd=%h dd=%b",
                     k, mem_addr, d_rvalid, i_rvalid, d_rdata, d_done);
         end
         tick();
      end
      d_req = 0;
      #1;
      vecs++;
      if (busy !== 1'b0 || grant !== 2'b00) begin
         errs++; $display("FAIL prio_turnaround: busy=%b grant=%b, want 0/00", busy, grant);
      end
      tick();
      vecs++;
      if (grant !== 2'b01 || mem_addr !== 32'h300) begin
         errs++; $display("FAIL prio_i_grant: grant=%b addr=%h, want 01/00000300", grant, mem_addr);
      end
      for (int k = 0; k < 4; k++) tick();
      i_req = 0; mem_ack = 0;
      tick();
   endtask

   task automatic test_write_back();
      logic [31:0] wd [4];
      wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003; wd[3] = 32'hDDDD_0004;
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = wd[0];
      tick();
      for (int c = 0; c < 8; c++) begin
         d_wdata = wd[c/2];
         mem_ack = (c % 2 == 1);
         #1;
         vecs++;
         if (mem_addr !== 32'h2000 + 32'(4*(c/2)) || mem_we !== 1'b1 || mem_wdata !== wd[c/2] ||
             d_wready !== mem_ack || d_rvalid !== 1'b0 || d_done !== (c == 7)) begin
            errs++;
            $display("FAIL wb_cyc%0d: addr=%h we=%b wdata=%h wready=%b done=%b, want addr=%h wdata=%h",
                     c, mem_addr, mem_we, mem_wdata, d_wready, d_done, 32'h2000 + 32'(4*(c/2)), wd[c/2]);
         end
         tick();
      end
      d_req = 0; d_we = 0; mem_ack = 0;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      i_req = 1; i_addr = 32'h500;
      tick();
      mem_ack = 1;
      tick(); tick();
      mem_ack = 0; rst = 1;
      tick();
      rst = 0;
      #1;
      vecs++;
      if (mem_req !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || i_done !== 1'b0) begin
         errs++; $display("FAIL rst_mid: req=%b grant=%b busy=%b done=%b, want 0/00/0/0",
                          mem_req, grant, busy, i_done);
      end
      tick();
      vecs++;
      if (grant !== 2'b01 || mem_addr !== 32'h500) begin
         errs++; $display("FAIL rst_restart: grant=%b addr=%h, want 01/00000500", grant, mem_addr);
      end
      mem_ack = 1;
      for (int k = 0; k < 4; k++) tick();
      i_req = 0; mem_ack = 0;
      tick();
   endtask

   task automatic test_req_drop();
      i_req = 1; i_addr = 32'h7F0;
      tick();
      mem_ack = 1;
      tick();
      i_req = 0;
      for (int k = 1; k < 4; k++) begin
         #1;
         vecs++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h7F0 + 32'(4*k) || i_done !== (k == 3)) begin
            errs++; $display("FAIL drop_beat%0d: req=%b addr=%h done=%b", k, mem_req, mem_addr, i_done);
         end
         tick();
      end
      mem_ack = 0;
      tick();
   endtask

   task automatic test_arbitration();
      logic [1:0] exp_g [3];
`ifdef ARB_ROUND_ROBIN_EN
      exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
`else
      exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b10;
`endif
      i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h40; d_addr = 32'h80;
      for (int t = 0; t < 3; t++) begin
         tick();
         vecs++;
         if (grant !== exp_g[t]) begin
            errs++; $display("FAIL arb_xfer%0d: grant=%b, want %b", t, grant, exp_g[t]);
         end
         mem_ack = 1;
         for (int k = 0; k < 4; k++) tick();
         mem_ack = 0;
         #1;
         vecs++;
         if (busy !== 1'b0) begin
            errs++; $display("FAIL arb_idle%0d: busy=%b, want 0", t, busy);
         end
      end
      i_req = 0; d_req = 0;
      tick(); tick();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_i_refill();
      test_priority();
      test_write_back();
      test_reset_mid_burst();
      test_req_drop();
      test_arbitration();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
